// File: rtl/sma_seq_ctrl.sv
// Host-commanded sequencer for one SMA pass: EMEM/DMEM/IMEM load streams,
// run handshake under a watchdog, then a readback stream.
module sma_seq_ctrl #(
    parameter int unsigned EAW   = 7,
    parameter int unsigned DAW   = 7,
    parameter int unsigned IAW   = 8,
    parameter int unsigned RAW   = 7,
    parameter int unsigned TMO_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic [EAW-1:0]   ELAST,
    input  logic [DAW-1:0]   DLAST,
    input  logic [IAW-1:0]   ILAST,
    input  logic [RAW-1:0]   RLAST,
    input  logic [TMO_W-1:0] TMO,
    input  logic             MEM_RDY,
    input  logic             DONE,
    output logic [EAW-1:0]   EADR,
    output logic             EWE,
    output logic [DAW-1:0]   DADR,
    output logic             DWE,
    output logic [IAW-1:0]   IADR,
    output logic             IWE,
    output logic [RAW-1:0]   RADR,
    output logic             RRE,
    output logic             RUN_GO,
    output logic             BUSY,
    output logic             FIN,
    output logic             ERR,
    output logic [8:0]       stat
);

    typedef enum logic [8:0] {
        S_IDLE = 9'h001,
        S_EMEM = 9'h002,
        S_DMEM = 9'h004,
        S_IMEM = 9'h008,
        S_GO   = 9'h010,
        S_RUN  = 9'h020,
        S_READ = 9'h040,
        S_FIN  = 9'h080,
        S_ERR  = 9'h100
    } state_e;

    state_e           state_q, state_d;
    logic [EAW-1:0]   elast_q, elast_d, eadr_q, eadr_d;
    logic [DAW-1:0]   dlast_q, dlast_d, dadr_q, dadr_d;
    logic [IAW-1:0]   ilast_q, ilast_d, iadr_q, iadr_d;
    logic [RAW-1:0]   rlast_q, rlast_d, radr_q, radr_d;
    logic [TMO_W-1:0] tmo_q, tmo_d, cnt_q, cnt_d;
    logic             ewe_q, ewe_d, dwe_q, dwe_d, iwe_q, iwe_d, rre_q, rre_d;
    logic             run_go_q, run_go_d, busy_q, busy_d;
    logic             fin_q, fin_d, err_q, err_d;

    always_comb begin
        state_d = state_q;
        elast_d = elast_q;
        dlast_d = dlast_q;
        ilast_d = ilast_q;
        rlast_d = rlast_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        eadr_d  = eadr_q;
        dadr_d  = dadr_q;
        iadr_d  = iadr_q;
        radr_d  = radr_q;

        // ABORT outranks everything, including START in IDLE
        if (ABORT) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        elast_d = ELAST;
                        dlast_d = DLAST;
                        ilast_d = ILAST;
                        rlast_d = RLAST;
                        tmo_d   = TMO;
                        eadr_d  = '0;
                        dadr_d  = '0;
                        iadr_d  = '0;
                        radr_d  = '0;
                        state_d = S_EMEM;
                    end
                end
                S_EMEM: begin
                    if (MEM_RDY) begin
                        if (eadr_q == elast_q) state_d = S_DMEM;
                        else                   eadr_d  = eadr_q + EAW'(1);
                    end
                end
                S_DMEM: begin
                    if (MEM_RDY) begin
                        if (dadr_q == dlast_q) state_d = S_IMEM;
                        else                   dadr_d  = dadr_q + DAW'(1);
                    end
                end
                S_IMEM: begin
                    if (MEM_RDY) begin
                        if (iadr_q == ilast_q) begin
                            state_d = S_GO;
                            cnt_d   = '0;
                        end else begin
                            iadr_d = iadr_q + IAW'(1);
                        end
                    end
                end
                // Counter tracks cycles elapsed since the RUN_GO cycle
                S_GO: begin
                    cnt_d   = cnt_q + TMO_W'(1);
                    state_d = S_RUN;
                end
                S_RUN: begin
                    if (DONE)                state_d = S_READ;
                    else if (cnt_q >= tmo_q) state_d = S_ERR;
                    else                     cnt_d   = cnt_q + TMO_W'(1);
                end
                S_READ: begin
                    if (MEM_RDY) begin
                        if (radr_q == rlast_q) state_d = S_FIN;
                        else                   radr_d  = radr_q + RAW'(1);
                    end
                end
                S_FIN:   state_d = S_IDLE;
                S_ERR:   state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase
        end

        ewe_d    = (state_d == S_EMEM);
        dwe_d    = (state_d == S_DMEM);
        iwe_d    = (state_d == S_IMEM);
        rre_d    = (state_d == S_READ);
        run_go_d = (state_d == S_GO);
        fin_d    = (state_d == S_FIN);
        err_d    = (state_d == S_ERR);
        busy_d   = !((state_d == S_IDLE) || (state_d == S_FIN) || (state_d == S_ERR));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            elast_q  <= '0;
            dlast_q  <= '0;
            ilast_q  <= '0;
            rlast_q  <= '0;
            tmo_q    <= '0;
            cnt_q    <= '0;
            eadr_q   <= '0;
            dadr_q   <= '0;
            iadr_q   <= '0;
            radr_q   <= '0;
            ewe_q    <= 1'b0;
            dwe_q    <= 1'b0;
            iwe_q    <= 1'b0;
            rre_q    <= 1'b0;
            run_go_q <= 1'b0;
            busy_q   <= 1'b0;
            fin_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            elast_q  <= elast_d;
            dlast_q  <= dlast_d;
            ilast_q  <= ilast_d;
            rlast_q  <= rlast_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
            eadr_q   <= eadr_d;
            dadr_q   <= dadr_d;
            iadr_q   <= iadr_d;
            radr_q   <= radr_d;
            ewe_q    <= ewe_d;
            dwe_q    <= dwe_d;
            iwe_q    <= iwe_d;
            rre_q    <= rre_d;
            run_go_q <= run_go_d;
            busy_q   <= busy_d;
            fin_q    <= fin_d;
            err_q    <= err_d;
        end
    end

    assign EADR   = eadr_q;
    assign EWE    = ewe_q;
    assign DADR   = dadr_q;
    assign DWE    = dwe_q;
    assign IADR   = iadr_q;
    assign IWE    = iwe_q;
    assign RADR   = radr_q;
    assign RRE    = rre_q;
    assign RUN_GO = run_go_q;
    assign BUSY   = busy_q;
    assign FIN    = fin_q;
    assign ERR    = err_q;
    assign stat   = state_q;

endmodule
